seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Reads a multiplexed, active-low 7-segment display bus: shared segment lines plus one active-low select line per digit. This is the bus our hex-to-7seg decoders drive.
- Converts each digit's segment pattern back into a hex nibble and assembles a full NDIG-digit value.
- Used as a loop-back checker and front-panel readback unit between the display driver and the test/UART logic.
- Filters scan glitches with a stability counter. Flags illegal patterns and illegal digit selects.

Parameters:
NDIG, 4, number of multiplexed digits (legal range 1..8)
STABLE_CYC, 4, consecutive identical compares required before a sample is accepted (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
seg_n  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
dig_n  input  NDIG  digit selects, active-low; bit i low means digit i is driven
value  output  4*NDIG  live decoded value; nibble i holds digit i
digit_valid  output  NDIG  bit i = nibble i holds a legally decoded pattern
frame_value  output  4*NDIG  snapshot of value taken when every digit has been accepted
frame_stb  output  1  one-cycle pulse when frame_value updates
bad_pattern  output  1  one-cycle pulse: accepted sample had a non-hex pattern
bad_select  output  1  one-cycle pulse: accepted sample had more than one dig_n bit low

Behaviour:
- Reset (async, rst=1):
  - value, frame_value, digit_valid and the seen mask are all 0.
  - All strobes are 0. Stability counter cnt is 0.
  - Input register r is all ones (blank display).
- Input stage:
  - Every edge, r <= {dig_n, seg_n}.
  - If {dig_n, seg_n} == r, then cnt <= min(cnt+1, STABLE_CYC); otherwise cnt <= 0.
- Accept event:
  - Occurs on the edge where cnt goes from STABLE_CYC-1 to STABLE_CYC.
  - Exactly one accept per stable interval. A held input does not re-accept.
  - Latency: an input applied before edge 0 and held is accepted, and its outputs update, at edge STABLE_CYC+1.
- Decode of p = ~seg_n, nibble = pattern:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47
  - Any other pattern is illegal.
- On accept, by dig_n contents:
  - dig_n all ones (blanking interval): no action, no flag.
  - More than one bit low: bad_select=1 for one cycle; value, digit_valid and seen unchanged.
  - Exactly bit i low, legal pattern: nibble i <= code, digit_valid[i] <= 1, seen[i] <= 1.
  - Exactly bit i low, illegal pattern: nibble i retained, digit_valid[i] <= 0, seen[i] <= 0, bad_pattern=1 for one cycle.
- Frame completion:
  - When a legal accept makes seen all ones, frame_value <= updated value (including the nibble written on that edge).
  - On the same edge frame_stb=1 for one cycle and seen <= 0.
  - Digits may arrive in any order. Re-accepting an already-seen digit overwrites its nibble and does not generate a strobe.
- Simultaneous events:
  - bad_pattern and bad_select are mutually exclusive.
  - frame_stb never coincides with either of them.
- Reset mid-frame: all state is cleared immediately. Partial seen progress is discarded.
- Arithmetic:
  - cnt width is 8 bits and saturates; it never wraps.
  - Digit index is decoded from one-hot dig_n with no priority encoding; multiple-low is the error case above.

Test Plan:
- Reset: assert rst mid-run with outputs nonzero -> outputs zero asynchronously; after release, no strobes until a new accept.
- Single digit (NDIG=4, STABLE_CYC=4): seg_n=7'b1001111, dig_n=4'b1110, held 8 cycles -> at edge 5 value[3:0]=1, digit_valid=4'b0001; no further updates; frame_stb stays 0.
- Glitch: same input held 3 cycles, then seg_n changes -> no accept, value unchanged; the new pattern is accepted only after 4 more stable compares.
- Full frame: digits 0..3 show A, B, C, D (~77, ~1F, ~4E, ~3D), each held 6 cycles with a 2-cycle blank between -> frame_value=16'hDCBA, exactly one frame_stb pulse on digit 3's accept edge.
- Illegal pattern: seg_n=~7'h01 on dig_n=4'b1011 -> bad_pattern pulse, digit_valid[2]=0, value[11:8] retained.
- Bad select: dig_n=4'b1100 stable -> bad_select single pulse; value, digit_valid and seen unchanged; a subsequent legal frame still completes normally.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus, filters scan glitches and
// rebuilds the displayed NDIG-digit hex value, flagging illegal patterns/selects.
module seg7_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_n,
    input  logic [NDIG-1:0]      dig_n,
    output logic [4*NDIG-1:0]    value,
    output logic [NDIG-1:0]      digit_valid,
    output logic [4*NDIG-1:0]    frame_value,
    output logic                 frame_stb,
    output logic                 bad_pattern,
    output logic                 bad_select
);

    localparam int         RW       = NDIG + 7;
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYC);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

    // Returns {legal, nibble} for an active-high segment pattern (a..g = bit6..bit0).
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] res;
        case (p)
            7'h7E:   res = 5'h10;
            7'h30:   res = 5'h11;
            7'h6D:   res = 5'h12;
            7'h79:   res = 5'h13;
            7'h33:   res = 5'h14;
            7'h5B:   res = 5'h15;
            7'h5F:   res = 5'h16;
            7'h70:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h7B:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h1F:   res = 5'h1B;
            7'h4E:   res = 5'h1C;
            7'h3D:   res = 5'h1D;
            7'h4F:   res = 5'h1E;
            7'h47:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [RW-1:0]       r_q;
    logic [7:0]          cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic [4*NDIG-1:0]   value_q, value_d;
    logic [NDIG-1:0]     valid_q, valid_d;
    logic [NDIG-1:0]     seen_q, seen_d;
    logic [4*NDIG-1:0]   frame_q, frame_d;
    logic                stb_q, stb_d;
    logic                bpat_q, bpat_d;
    logic                bsel_q, bsel_d;

    logic                same_s;
    logic [NDIG-1:0]     sel_s;
    logic [NDIG-1:0]     seen_new_s;
    logic [3:0]          pop_s;
    logic [4:0]          dec_s;

    // Stability counter: saturates at STABLE_CYC so a held input accepts only once.
    always_comb begin
        same_s = ({dig_n, seg_n} == r_q);
        if (!same_s) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        acc_d = same_s && (cnt_q == CNT_LAST);
    end

    // The accepted sample is still held in r_q one cycle later (it was reloaded
    // with an identical value on the accept edge), so it is decoded from there.
    always_comb begin
        sel_s = ~r_q[RW-1:7];
        dec_s = seg_decode(~r_q[6:0]);
        pop_s = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            pop_s = pop_s + {3'b000, sel_s[i]};
        end
    end

    // Digit update, error flags and frame assembly.
    always_comb begin
        value_d    = value_q;
        valid_d    = valid_q;
        seen_d     = seen_q;
        frame_d    = frame_q;
        stb_d      = 1'b0;
        bpat_d     = 1'b0;
        bsel_d     = 1'b0;
        seen_new_s = seen_q | sel_s;
        if (!acc_q) begin
            value_d = value_q;
        end else if (pop_s > 4'd1) begin
            bsel_d = 1'b1;
        end else if (pop_s == 4'd1) begin
            if (dec_s[4]) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (sel_s[i]) begin
                        value_d[4*i +: 4] = dec_s[3:0];
                    end else begin
                        value_d[4*i +: 4] = value_q[4*i +: 4];
                    end
                end
                valid_d = valid_q | sel_s;
                if (seen_new_s == {NDIG{1'b1}}) begin
                    frame_d = value_d;
                    stb_d   = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d  = seen_new_s;
                end
            end else begin
                valid_d = valid_q & ~sel_s;
                seen_d  = seen_q & ~sel_s;
                bpat_d  = 1'b1;
            end
        end else begin
            value_d = value_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '1;
            cnt_q   <= 8'd0;
            acc_q   <= 1'b0;
            value_q <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= '0;
            stb_q   <= 1'b0;
            bpat_q  <= 1'b0;
            bsel_q  <= 1'b0;
        end else begin
            r_q     <= {dig_n, seg_n};
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            stb_q   <= stb_d;
            bpat_q  <= bpat_d;
            bsel_q  <= bsel_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign frame_value = frame_q;
    assign frame_stb   = stb_q;
    assign bad_pattern = bpat_q;
    assign bad_select  = bsel_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader (NDIG=4, STABLE_CYC=4).
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [15:0] frame_value;
    logic        frame_stb;
    logic        bad_pattern;
    logic        bad_select;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stb   = 0;
    int n_bpat  = 0;
    int n_bsel  = 0;
    int s_stb, s_bpat, s_bsel;

    seg7_scan_reader #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_value (frame_value),
        .frame_stb   (frame_stb),
        .bad_pattern (bad_pattern),
        .bad_select  (bad_select)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_stb)   n_stb++;
        if (bad_pattern) n_bpat++;
        if (bad_select)  n_bsel++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a bus state and hold it for n rising edges; returns 1 time unit after the last edge.
    task automatic drive(input logic [6:0] pat, input logic [3:0] dig, input int n);
        seg_n = ~pat;
        dig_n = dig;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_stb  = n_stb;
        s_bpat = n_bpat;
        s_bsel = n_bsel;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_frame", 32'(frame_value), 32'h0);
        check("rst_strobes", {29'd0, frame_stb, bad_pattern, bad_select}, 32'h0);
        drive(7'h00, 4'hF, 8);

        // Single digit '1' on digit 0: update exactly on the 6th edge after application
        snap();
        drive(7'h30, 4'b1110, 5);
        check("single_early", 32'(value), 32'h0);
        drive(7'h30, 4'b1110, 1);
        check("single_value", 32'(value), 32'h0001);
        check("single_valid", 32'(digit_valid), 32'h1);
        drive(7'h30, 4'b1110, 2);
        check("single_hold", 32'(value), 32'h0001);
        check("single_nostb", 32'(n_stb - s_stb), 32'd0);

        // Glitch: 'C' held only 3 edges, then '4' on digit 1
        drive(7'h4E, 4'b1101, 3);
        drive(7'h33, 4'b1101, 5);
        check("glitch_noacc", 32'(value), 32'h0001);
        drive(7'h33, 4'b1101, 1);
        check("glitch_value", 32'(value), 32'h0041);
        check("glitch_valid", 32'(digit_valid), 32'h3);

        // Async reset mid-cycle with nonzero outputs
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_value", 32'(value), 32'h0);
        check("arst_valid", 32'(digit_valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        snap();
        drive(7'h00, 4'hF, 8);
        check("arst_nostb", 32'(n_stb - s_stb + n_bpat - s_bpat + n_bsel - s_bsel), 32'd0);

        // Seen progress was discarded: digits 2,3 alone must not complete a frame
        drive(7'h7B, 4'b1011, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h4F, 4'b0111, 6);
        drive(7'h00, 4'hF, 2);
        check("partial_nostb", 32'(n_stb - s_stb), 32'd0);
        check("partial_frame", 32'(frame_value), 32'h0);
        drive(7'h7E, 4'b1110, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h47, 4'b1101, 6);
        check("partial_done", 32'(frame_value), 32'hE9F0);
        drive(7'h00, 4'hF, 2);
        check("partial_stb", 32'(n_stb - s_stb), 32'd1);

        // Full frame A,B,C,D in order
        snap();
        drive(7'h77, 4'b1110, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h1F, 4'b1101, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h4E, 4'b1011, 6);
        drive(7'h00, 4'hF, 2);
        check("frame_pending", 32'(frame_value), 32'hE9F0);
        check("frame_nostb", 32'(n_stb - s_stb), 32'd0);
        drive(7'h3D, 4'b0111, 6);
        check("frame_stb_edge", 32'(frame_stb), 32'd1);
        check("frame_value", 32'(frame_value), 32'hDCBA);
        drive(7'h00, 4'hF, 2);
        check("frame_one_stb", 32'(n_stb - s_stb), 32'd1);
        check("frame_valid", 32'(digit_valid), 32'hF);

        // Illegal pattern on digit 2
        snap();
        drive(7'h01, 4'b1011, 6);
        check("bpat_pulse", 32'(bad_pattern), 32'd1);
        check("bpat_valid", 32'(digit_valid), 32'hB);
        check("bpat_value", 32'(value), 32'hDCBA);
        drive(7'h01, 4'b1011, 4);
        check("bpat_once", 32'(n_bpat - s_bpat), 32'd1);
        check("bpat_nosel", 32'(n_bsel - s_bsel), 32'd0);

        // Bad select, then a frame in reverse order still completes
        snap();
        drive(7'h77, 4'b1100, 6);
        check("bsel_pulse", 32'(bad_select), 32'd1);
        check("bsel_value", 32'(value), 32'hDCBA);
        check("bsel_valid", 32'(digit_valid), 32'hB);
        drive(7'h77, 4'b1100, 4);
        check("bsel_once", 32'(n_bsel - s_bsel), 32'd1);
        check("bsel_nopat", 32'(n_bpat - s_bpat), 32'd0);
        drive(7'h5B, 4'b0111, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h5F, 4'b1011, 6);
        drive(7'h00, 4'hF, 2);
        drive(7'h70, 4'b1101, 6);
        drive(7'h00, 4'hF, 2);
        check("rev_nostb", 32'(n_stb - s_stb), 32'd0);
        drive(7'h7F, 4'b1110, 6);
        drive(7'h00, 4'hF, 2);
        check("rev_frame", 32'(frame_value), 32'h5678);
        check("rev_stb", 32'(n_stb - s_stb), 32'd1);
        check("rev_valid", 32'(digit_valid), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
